vram_writer: RTL
================

# vram_writer

Host-side write port into the shared 256K×16 video SRAM that the background fetcher reads tile maps and tile data from. It buffers host writes (address + data + byte enables) in a small FIFO and turns each entry into a three-phase SRAM write cycle. It drives the SRAM only in slots the top-level arbiter grants, so tile-map and tile-pattern updates never disturb scan-line fetches.

## Interface
- FIFO_DEPTH, 4: number of buffered write entries (power of two, ≥2).
- ADDR_STEP, 1: auto-increment applied to the host address after each accepted word.
- clk  in  1  system clock (same clock as background fetch logic).
- reset  in  1  synchronous, active-high reset.
- set_addr  in  1  load addr_in into the host address counter this cycle.
- addr_in  in  18  word address to load.
- wr_valid  in  1  host offers wr_data/wr_be this cycle.
- wr_data  in  16  word to write.
- wr_be  in  2  byte enables, [0] = low byte, [1] = high byte.
- wr_ready  out  1  FIFO can accept a word (not full).
- pending  out  3  entries in FIFO plus in-flight write (0..FIFO_DEPTH+1; width sized for default).
- bus_req  out  1  high while FIFO non-empty or a write is in flight.
- bus_grant  in  1  arbiter allows this block to start an SRAM cycle.
- bus_busy  out  1  block owns the SRAM; arbiter must keep the bus here while high.
- ram_addr  out  18  SRAM address.
- ram_dout  out  16  SRAM write data.
- ram_ce, ram_oe, ram_we  out  1 each  SRAM controls, active-high as at top level.
- ram_lb, ram_hb  out  1 each  byte lane enables, active-high.

## Operation
- Host address counter haddr (18 bits). A push (wr_valid & wr_ready) stores {entry address, wr_data, wr_be} in the FIFO:
  - set_addr with no push: haddr <= addr_in.
  - push without set_addr: entry uses haddr; haddr <= haddr + ADDR_STEP.
  - set_addr and push in the same cycle: entry uses addr_in; haddr <= addr_in + ADDR_STEP.
  - Address arithmetic is mod 2^18 (0x3FFFF + 1 wraps to 0x00000).
- wr_ready = !full. A push while full is ignored and leaves FIFO state unchanged.
- Write FSM, all outputs registered:
  - IDLE: ce=oe=we=0, lb=hb=0, bus_busy=0. If FIFO non-empty and bus_grant, pop the head, latch addr/data/be, go to SETUP.
  - SETUP: ce=1, we=0, addr/dout/lb/hb valid, bus_busy=1.
  - STROBE: ce=1, we=1, all else held.
  - HOLD: ce=1, we=0, all else held. Then go to IDLE.
- ram_oe is 0 in every state. The block never reads.
- bus_grant is sampled only in IDLE. Once SETUP is entered the cycle always completes, even if grant drops.
- wr_be = 2'b00 entries still run a full cycle with lb=hb=0, so no bytes are written.
- Entries are written in push order.

## Timing
- Reset: ram_addr=0, ram_dout=0, all ram controls 0, bus_req=0, bus_busy=0, pending=0, haddr=0, FIFO empty, FSM IDLE. wr_ready=0 while reset is high and 1 on the first cycle after.
- Reset mid-write: next cycle is IDLE with all controls 0. FIFO contents and the in-flight word are discarded.
- Push at cycle N:
  - Entry is visible at N+1. bus_req and pending reflect it at N+1.
  - If bus_grant is high at N+1: SETUP at N+2, STROBE (we=1) at N+3, HOLD at N+4, IDLE at N+5.
- With grant held high, throughput is one word per 4 cycles. The next SETUP can be at N+6.
- pending counts the in-flight word from SETUP through HOLD. A push and a pop in the same cycle leave the FIFO count unchanged.
- bus_req drops the cycle after the final HOLD when the FIFO is empty.

## Test plan
- Reset, grant=1; set_addr addr_in=0x02000 and push 0xABCD be=11 in the same cycle -> SETUP 2 cycles later with ram_addr=0x02000, ram_dout=0xABCD, lb=hb=1; we=1 for exactly one cycle; haddr=0x02001.
- grant=1; push 6 words back-to-back from 0x3FFFE with FIFO_DEPTH=4 -> wr_ready low after 4 buffered (plus drain); written addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001, ... in order; the over-full push is held off, not lost.
- grant=0; push 2 words -> bus_req=1, pending=2, no ce/we activity; raise grant -> both words written, 4 cycles apart.
- Drop grant in the cycle after SETUP -> STROBE and HOLD still occur; the next entry waits in IDLE until grant returns.
- Push with be=01 then be=00 -> first cycle lb=1, hb=0; second cycle runs with lb=hb=0; ram_oe stays 0 throughout.
- Assert reset during STROBE with 3 entries pending -> next cycle all controls 0, pending=0, bus_req=0; no further writes occur.

Source files
------------

// File: rtl/vram_writer.sv
// vram_writer: host-side write port into the shared 256Kx16 video SRAM.
//
// Host writes (address + data + byte enables) are buffered in a small FIFO.
// Each entry becomes a three-phase SRAM write (SETUP / STROBE / HOLD). A
// cycle starts only in a slot the arbiter grants, so tile-map and pattern
// updates never disturb scan-line fetches.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   set_addr, addr_in   load the host address counter
//   wr_valid, wr_data,  host write offer: 16-bit word, byte enables
//   wr_be               ([0] = low byte, [1] = high byte)
//   wr_ready            FIFO can accept a word
//   pending             FIFO entries plus the in-flight write
//   bus_req             work is waiting or in progress
//   bus_grant           arbiter lets this block start an SRAM cycle
//   bus_busy            block owns the SRAM; the arbiter must hold the bus
//   ram_*               SRAM address, write data, active-high controls
module vram_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_STEP  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_addr,
  input  logic [17:0] addr_in,
  input  logic        wr_valid,
  input  logic [15:0] wr_data,
  input  logic [1:0]  wr_be,
  output logic        wr_ready,
  output logic [2:0]  pending,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic        bus_busy,
  output logic [17:0] ram_addr,
  output logic [15:0] ram_dout,
  output logic        ram_ce,
  output logic        ram_oe,
  output logic        ram_we,
  output logic        ram_lb,
  output logic        ram_hb
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [17:0] STEP = 18'(ADDR_STEP);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } entry_t;

  state_t state_q, next_state;

  entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [17:0]        haddr;
  logic [17:0]        entry_addr;
  logic               full, empty, push, pop;
  logic               ce_d, we_d;
  entry_t             head;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  // Held low during reset so the host never sees a slot that is about to vanish.
  assign wr_ready = ~full & ~reset;
  assign push     = wr_valid & wr_ready;
  // Grant is only consulted in IDLE; a started cycle always runs to HOLD.
  assign pop      = (state_q == S_IDLE) & ~empty & bus_grant;
  assign head     = mem[rd_ptr];

  // A set_addr in the same cycle as a push redirects that very entry.
  assign entry_addr = set_addr ? addr_in : haddr;

  // ---------------------------------------------------------------- host addr
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      haddr <= '0;
    end else if (push) begin
      haddr <= entry_addr + STEP;
    end else if (set_addr) begin
      haddr <= addr_in;
    end
  end

  // --------------------------------------------------------------------- FIFO
  // NOTE: the storage array has no reset; count and pointers alone decide
  // which slots hold valid data, which keeps the array as plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{addr: entry_addr, data: wr_data, be: wr_be};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- write FSM
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state_q;
    case (state_q)
      S_IDLE:   if (pop) next_state = S_SETUP;
      S_SETUP:  next_state = S_STROBE;
      S_STROBE: next_state = S_HOLD;
      S_HOLD:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Controls are decoded from the upcoming state and then registered, so the
  // SRAM pins come straight from flops.
  always_comb begin
    ce_d = 1'b0;
    we_d = 1'b0;
    case (next_state)
      S_SETUP, S_HOLD: ce_d = 1'b1;
      S_STROBE: begin
        ce_d = 1'b1;
        we_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_ce   <= 1'b0;
      ram_we   <= 1'b0;
      bus_busy <= 1'b0;
      ram_addr <= '0;
      ram_dout <= '0;
      ram_lb   <= 1'b0;
      ram_hb   <= 1'b0;
    end else begin
      ram_ce   <= ce_d;
      ram_we   <= we_d;
      bus_busy <= ce_d;
      if (pop) begin
        ram_addr <= head.addr;
        ram_dout <= head.data;
        ram_lb   <= head.be[0];
        ram_hb   <= head.be[1];
      end else if (next_state == S_IDLE) begin
        // Address and data may linger; lane enables must not.
        ram_lb <= 1'b0;
        ram_hb <= 1'b0;
      end
    end
  end

  // The block only writes.
  assign ram_oe = 1'b0;

  assign bus_req = ~empty | (state_q != S_IDLE);
  assign pending = 3'(count) + 3'(state_q != S_IDLE);

endmodule
